// File: rtl/fft_pkg.sv
// Shared definitions for the FFT frame arbiter: frame geometry, requester ids,
// arbiter state encoding and the round-robin pick rule.
package fft_pkg;

    localparam int FFT_FRAME_LEN  = 16;
    localparam int DATA_W_DEFAULT = 16;
    localparam int N_REQ          = 2;
    localparam int ID_W           = 1;

    typedef logic [ID_W-1:0] req_id_t;

    // One-hot, matching the encoding style of the core's own control FSM.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b01,
        ST_FWD  = 2'b10
    } arb_state_t;

    // Round-robin: on a tie the requester that did not win last time goes next.
    function automatic req_id_t rr_pick(input logic [N_REQ-1:0] valid, input req_id_t last);
        req_id_t pick;
        if (valid == 2'b11) begin
            pick = ~last;
        end else if (valid[1]) begin
            pick = 1'b1;
        end else begin
            pick = 1'b0;
        end
        return pick;
    endfunction

endpackage

// File: rtl/fft_owner_fifo.sv
// Small FIFO of requester ids, one entry per frame handed to the core and not
// yet returned. Push and pop in the same cycle leave the occupancy unchanged.
module fft_owner_fifo
    import fft_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    reset_n,
    input  logic    push,
    input  req_id_t push_id,
    input  logic    pop,
    output req_id_t head_id,
    output logic    full,
    output logic    empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);

    req_id_t          mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == OCC_W'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A pop frees the slot the simultaneous push lands in.
    assign do_push = push & (~full | do_pop);
    assign head_id = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_id;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + OCC_W'(1);
                2'b01:   count <= count - OCC_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fft_frame_arbiter.sv
// Round-robin arbiter sharing one 16-point FFT core between two requesters,
// granting whole input frames and routing each output frame back to its owner.
module fft_frame_arbiter
    import fft_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEFAULT,
    parameter int FRAME_LEN = FFT_FRAME_LEN,
    parameter int OQ_DEPTH  = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [1:0]          req_valid,
    input  logic [1:0]          req_push,
    input  logic [2*DATA_W-1:0] req_real,
    input  logic [2*DATA_W-1:0] req_imag,
    output logic [1:0]          req_stall,
    output logic                core_in_push,
    output logic [DATA_W-1:0]   core_in_real,
    output logic [DATA_W-1:0]   core_in_imag,
    input  logic                core_in_stall,
    input  logic                core_out_push,
    output logic                core_out_stall,
    output logic [1:0]          out_push,
    output logic                out_last,
    output logic                grant_busy,
    output logic                err_orphan
);

    localparam int               CW       = $clog2(FRAME_LEN);
    localparam logic [CW-1:0]    CNT_LAST = CW'(FRAME_LEN - 1);

    arb_state_t    state;
    arb_state_t    state_next;
    req_id_t       owner;
    req_id_t       last_grant;
    req_id_t       pick;
    req_id_t       q_head;
    logic [CW-1:0] in_cnt;
    logic [CW-1:0] out_cnt;
    logic          q_full;
    logic          q_empty;
    logic          grant_take;
    logic          in_accept;
    logic          in_last;
    logic          out_valid;
    logic          out_pop;

    assign pick       = rr_pick(req_valid, last_grant);
    assign grant_take = (state == ST_IDLE) & (|req_valid) & ~q_full;

    // Push/stall handshake on every port: a sample moves on the clock edge
    // where push is high and stall is low; stall is the receiver's not-ready.
    assign in_accept = (state == ST_FWD) & req_push[owner] & ~core_in_stall;
    assign in_last   = in_accept & (in_cnt == CNT_LAST);

    assign core_in_real = owner ? req_real[2*DATA_W-1:DATA_W] : req_real[DATA_W-1:0];
    assign core_in_imag = owner ? req_imag[2*DATA_W-1:DATA_W] : req_imag[DATA_W-1:0];

    always_comb begin
        state_next   = state;
        core_in_push = 1'b0;
        req_stall    = 2'b11;
        grant_busy   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (grant_take) begin
                    state_next = ST_FWD;
                end
            end
            ST_FWD: begin
                grant_busy       = 1'b1;
                core_in_push     = req_push[owner];
                req_stall[owner] = core_in_stall;
                if (in_last) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            owner      <= '0;
            last_grant <= '1;
            in_cnt     <= '0;
        end else begin
            state <= state_next;
            if (grant_take) begin
                owner      <= pick;
                last_grant <= pick;
            end
            // FRAME_LEN is a power of two, so the counter wraps on its own.
            if (in_accept) begin
                in_cnt <= in_cnt + CW'(1);
            end
        end
    end

    // Output side: the queue head names the owner of the frame now draining.
    assign out_valid      = core_out_push & ~q_empty;
    assign out_pop        = out_valid & (out_cnt == CNT_LAST);
    assign out_last       = out_pop;
    assign out_push       = {out_valid & q_head[0], out_valid & ~q_head[0]};
    assign core_out_stall = 1'b0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_cnt    <= '0;
            err_orphan <= 1'b0;
        end else begin
            if (out_valid) begin
                out_cnt <= out_cnt + CW'(1);
            end
            if (core_out_push & q_empty) begin
                err_orphan <= 1'b1;
            end
        end
    end

    fft_owner_fifo #(
        .DEPTH(OQ_DEPTH)
    ) u_owner_fifo (
        .clk    (clk),
        .reset_n(reset_n),
        .push   (in_last),
        .push_id(owner),
        .pop    (out_pop),
        .head_id(q_head),
        .full   (q_full),
        .empty  (q_empty)
    );

endmodule

// File: tb/tb_fft_frame_arbiter.sv
// Directed bench for fft_frame_arbiter: a vector table for idle/orphan/grant
// behaviour, then hand-written frame sequences checked against an expected queue.
module tb_fft_frame_arbiter;

    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [1:0]      req_valid;
    logic [1:0]      req_push;
    logic [2*DW-1:0] req_real;
    logic [2*DW-1:0] req_imag;
    logic [1:0]      req_stall;
    logic            core_in_push;
    logic [DW-1:0]   core_in_real;
    logic [DW-1:0]   core_in_imag;
    logic            core_in_stall;
    logic            core_out_push;
    logic            core_out_stall;
    logic [1:0]      out_push;
    logic            out_last;
    logic            grant_busy;
    logic            err_orphan;

    int          n_cmp = 0;
    int          n_err = 0;
    logic        mon_en = 1'b0;
    logic [16:0] exp_q[$];
    logic [16:0] mon_e;
    logic [15:0] mon_im;

    typedef struct {
        logic [1:0]  rv;
        logic [1:0]  rp;
        logic        cis;
        logic        cop;
        logic [1:0]  e_stall;
        logic        e_cip;
        logic        e_busy;
        logic [1:0]  e_out;
        logic        e_last;
        logic        e_orph;
        logic        chk_data;
        logic [15:0] e_real;
    } vec_t;

    vec_t vecs[11];

    fft_frame_arbiter dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req_valid     (req_valid),
        .req_push      (req_push),
        .req_real      (req_real),
        .req_imag      (req_imag),
        .req_stall     (req_stall),
        .core_in_push  (core_in_push),
        .core_in_real  (core_in_real),
        .core_in_imag  (core_in_imag),
        .core_in_stall (core_in_stall),
        .core_out_push (core_out_push),
        .core_out_stall(core_out_stall),
        .out_push      (out_push),
        .out_last      (out_last),
        .grant_busy    (grant_busy),
        .err_orphan    (err_orphan)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before the end of the test");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Every sample the core accepts must be the next expected one, from the right owner.
    always @(negedge clk) begin
        if (reset_n && mon_en && core_in_push && !core_in_stall) begin
            if (exp_q.size() == 0) begin
                check("unexpected_sample", 32'd1, 32'd0);
            end else begin
                mon_e  = exp_q.pop_front();
                mon_im = ~mon_e[15:0];
                check("in_real", core_in_real, mon_e[15:0]);
                check("in_imag", core_in_imag, mon_im);
                check("in_owner_stall", req_stall, mon_e[16] ? 2'b01 : 2'b10);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic put_sample(input int n, input logic [15:0] v);
        if (n == 0) begin
            req_real = {16'hDEAD, v};
            req_imag = {16'hBEEF, ~v};
        end else begin
            req_real = {v, 16'hDEAD};
            req_imag = {~v, 16'hBEEF};
        end
    endtask

    // Pushes one 16-sample frame for requester n, honouring req_stall.
    task automatic drive_frame(input int n, input logic [15:0] base, input int stall_at, input bit drop);
        int   i = 0;
        int   guard = 0;
        int   stall_left = 3;
        logic acc;
        logic stalled;
        for (int k = 0; k < 16; k++) exp_q.push_back({n[0], base + 16'(k)});
        req_push[n] = 1'b1;
        put_sample(n, base);
        while (i < 16 && guard < 300) begin
            stalled = (i == stall_at) && (stall_left > 0);
            core_in_stall = stalled;
            if (stalled) stall_left--;
            @(negedge clk);
            acc = grant_busy & ~req_stall[n];
            if (stalled) begin
                check("stall_req_stall", req_stall, 2'b11);
                check("stall_in_cnt_hold", dut.in_cnt, stall_at);
            end else if (acc && i == 0) begin
                check("first_in_cnt", dut.in_cnt, 0);
            end
            @(posedge clk); #1;
            if (acc) begin
                i++;
                put_sample(n, base + 16'(i));
            end
            guard++;
        end
        check("frame_accepted", i, 16);
        core_in_stall = 1'b0;
        req_push[n] = 1'b0;
        if (drop) req_valid = 2'b00;
        @(negedge clk);
        check("busy_after_frame", grant_busy, 0);
        @(posedge clk); #1;
    endtask

    task automatic return_frame(input int n);
        for (int k = 0; k < 16; k++) begin
            core_out_push = 1'b1;
            @(negedge clk);
            check("out_push", out_push, (n == 0) ? 2'b01 : 2'b10);
            check("out_last", out_last, k == 15);
            @(posedge clk); #1;
        end
        core_out_push = 1'b0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        req_valid     = 2'b00;
        req_push      = 2'b00;
        req_real      = {16'hBBBB, 16'hAAAA};
        req_imag      = {16'hDDDD, 16'hCCCC};
        core_in_stall = 1'b0;
        core_out_push = 1'b0;

        //              rv     rp   cis   cop  | stall cip  busy  out   last orph | chk  real
        vecs[0]  = '{2'b00, 2'b00, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0};
        vecs[1]  = '{2'b00, 2'b00, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0};
        vecs[2]  = '{2'b00, 2'b00, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 16'h0};
        vecs[3]  = '{2'b00, 2'b11, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 16'h0};
        vecs[4]  = '{2'b00, 2'b00, 1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 16'h0};
        vecs[5]  = '{2'b01, 2'b00, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 16'h0};
        vecs[6]  = '{2'b01, 2'b01, 1'b1, 1'b0, 2'b11, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 16'hAAAA};
        vecs[7]  = '{2'b01, 2'b00, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 16'h0};
        vecs[8]  = '{2'b00, 2'b01, 1'b0, 1'b0, 2'b10, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 16'hAAAA};
        vecs[9]  = '{2'b00, 2'b10, 1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 16'h0};
        vecs[10] = '{2'b10, 2'b00, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 16'h0};

        #12 reset_n = 1'b1;
        @(posedge clk); #1;

        // Reset state, orphan push, idle stalls, single-request grant, ignored valid drop.
        for (int i = 0; i < 11; i++) begin
            req_valid     = vecs[i].rv;
            req_push      = vecs[i].rp;
            core_in_stall = vecs[i].cis;
            core_out_push = vecs[i].cop;
            @(negedge clk);
            check($sformatf("v%0d_req_stall", i), req_stall, vecs[i].e_stall);
            check($sformatf("v%0d_core_in_push", i), core_in_push, vecs[i].e_cip);
            check($sformatf("v%0d_grant_busy", i), grant_busy, vecs[i].e_busy);
            check($sformatf("v%0d_out_push", i), out_push, vecs[i].e_out);
            check($sformatf("v%0d_out_last", i), out_last, vecs[i].e_last);
            check($sformatf("v%0d_err_orphan", i), err_orphan, vecs[i].e_orph);
            if (vecs[i].chk_data) begin
                check($sformatf("v%0d_core_in_real", i), core_in_real, vecs[i].e_real);
                check($sformatf("v%0d_core_in_imag", i), core_in_imag, 16'hCCCC);
            end
            @(posedge clk); #1;
        end

        // Advance requester 0's frame to in_cnt = 9, then reset between edges.
        req_valid     = 2'b01;
        req_push      = 2'b01;
        core_in_stall = 1'b0;
        core_out_push = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("pre_reset_in_cnt", dut.in_cnt, 9);
        check("pre_reset_busy", grant_busy, 1);
        #1 reset_n = 1'b0;
        #1;
        check("async_reset_busy", grant_busy, 0);
        check("async_reset_stall", req_stall, 2'b11);
        check("async_reset_core_in_push", core_in_push, 0);
        check("async_reset_err_orphan", err_orphan, 0);
        check("async_reset_in_cnt", dut.in_cnt, 0);
        #1 reset_n = 1'b1;
        req_valid = 2'b00;
        req_push  = 2'b00;
        @(posedge clk); #1;

        // Contention from reset: grants 0, 1, then 0 once the full queue drains one frame.
        mon_en = 1'b1;
        exp_q.delete();
        req_valid = 2'b11;
        drive_frame(0, 16'h0100, -1, 1'b0);
        drive_frame(1, 16'h0200, -1, 1'b0);
        return_frame(0);
        drive_frame(0, 16'h0300, -1, 1'b1);
        return_frame(1);
        return_frame(0);
        check("contention_err_orphan", err_orphan, 0);

        // Single frame with a 3-cycle core stall while sample 7 is presented.
        req_valid = 2'b01;
        drive_frame(0, 16'h0400, 7, 1'b1);
        return_frame(0);

        // Queue full: two frames outstanding block the third grant until the first pops.
        req_valid = 2'b01;
        drive_frame(0, 16'h0500, -1, 1'b0);
        drive_frame(0, 16'h0600, -1, 1'b0);
        req_push = 2'b01;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("qfull_busy", grant_busy, 0);
            check("qfull_stall", req_stall, 2'b11);
            check("qfull_core_in_push", core_in_push, 0);
            @(posedge clk); #1;
        end
        req_push = 2'b00;
        return_frame(0);
        @(negedge clk);
        check("pop_cycle_busy", grant_busy, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("grant_after_pop", grant_busy, 1);
        @(posedge clk); #1;
        drive_frame(0, 16'h0700, -1, 1'b1);
        return_frame(0);
        return_frame(0);

        check("exp_q_drained", exp_q.size(), 0);
        check("final_err_orphan", err_orphan, 0);
        check("final_core_out_stall", core_out_stall, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
